// File: rtl/encoder_16to4_seq.sv
// encoder_16to4_seq: captures a request vector and emits the index of each set bit, one per output handshake
module encoder_16to4_seq #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b0,
    localparam int IDX_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             zero_in
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;
    logic [0:0]       state;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] sel;
    assign in_ready  = state == IDLE;
    assign out_valid = state == EMIT;
    assign out_last  = out_valid && ((pending & (pending - WIDTH'(1))) == '0);
    always_comb begin
        out_index = '0;
        for (int k = 0; k < WIDTH; k++)
            if (pending[MSB_FIRST ? k : WIDTH-1-k])
                out_index = IDX_W'(MSB_FIRST ? k : WIDTH-1-k);
        sel = WIDTH'(1) << out_index;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            pending <= '0;
            zero_in <= 1'b0;
        end else begin
            zero_in <= in_valid && in_ready && in_vec == '0;
            if (in_valid && in_ready && in_vec != '0) begin
                pending <= in_vec;
                state   <= EMIT;
            end else if (out_valid && out_ready) begin
                pending <= pending & ~sel;
                state   <= out_last ? IDLE : EMIT;
            end
        end
    end
endmodule

// File: tb/tb_encoder_16to4_seq.sv
// tb_encoder_16to4_seq: scoreboard bench for the sequential 16-to-4 encoder
module tb_encoder_16to4_seq;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_last, zero_in;
    logic [15:0] in_vec = '0;
    logic [3:0] out_index;
    logic m_in_valid = 1'b0, m_in_ready, m_out_valid, m_out_ready = 1'b1, m_out_last, m_zero_in;
    logic [15:0] m_in_vec = '0;
    logic [3:0] m_out_index;
    int checks = 0;
    int errors = 0;
    int beats = 0;
    typedef struct { logic [3:0] idx; logic last; } beat_t;
    beat_t q[$];

    always #5 clk = ~clk;

    encoder_16to4_seq #(.WIDTH(16), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_vec(in_vec), .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_last(out_last), .zero_in(zero_in)
    );

    encoder_16to4_seq #(.WIDTH(16), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset_n(reset_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .in_vec(m_in_vec), .out_valid(m_out_valid), .out_ready(m_out_ready),
        .out_index(m_out_index), .out_last(m_out_last), .zero_in(m_zero_in)
    );

    always @(negedge clk) begin
        if (reset_n && out_valid && zero_in) begin
            errors++;
            $display("FAIL excl out_valid=%0b zero_in=%0b both high", out_valid, zero_in);
        end
        if (reset_n && out_valid && out_ready) begin
            beat_t e;
            checks++;
            beats++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL beat unexpected index %0d last %0b", out_index, out_last);
            end else begin
                e = q.pop_front();
                if (out_index !== e.idx || out_last !== e.last) begin
                    errors++;
                    $display("FAIL beat got idx %0d last %0b exp idx %0d last %0b",
                             out_index, out_last, e.idx, e.last);
                end
            end
        end
    end

    task automatic push_vec(input logic [15:0] v);
        int hi = -1;
        for (int i = 0; i < 16; i++) if (v[i]) hi = i;
        for (int i = 0; i < 16; i++)
            if (v[i]) q.push_back('{idx: 4'(i), last: (i == hi)});
    endtask

    task automatic send(input logic [15:0] v);
        int n = 0;
        push_vec(v);
        in_vec = v;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready) begin
            errors++;
            $display("FAIL send in_ready timeout got %0b exp 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s drain left %0d beats out_valid %0b exp 0", name, q.size(), out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || zero_in !== 1'b0) begin
            errors++;
            $display("FAIL reset in_ready %0b out_valid %0b zero_in %0b exp 1 0 0",
                     in_ready, out_valid, zero_in);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single;
        send(16'h0008);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL single latency out_valid %0b exp 1", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single after out_valid %0b in_ready %0b exp 0 1", out_valid, in_ready);
        end
        drain("single");
    endtask

    task automatic test_multi;
        send(16'h8421);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL multi beat %0d out_valid %0b in_ready %0b exp 1 0", i, out_valid, in_ready);
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL multi end out_valid %0b exp 0", out_valid);
        end
        drain("multi");
    endtask

    task automatic test_msb_first;
        logic [3:0] exp_idx [4] = '{4'd15, 4'd10, 4'd5, 4'd0};
        m_in_vec = 16'h8421;
        m_in_valid = 1'b1;
        @(posedge clk);
        #1 m_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (m_out_valid !== 1'b1 || m_out_index !== exp_idx[i] || m_out_last !== (i == 3)) begin
                errors++;
                $display("FAIL msb beat %0d got v%0b idx %0d last %0b exp v1 idx %0d last %0b",
                         i, m_out_valid, m_out_index, m_out_last, exp_idx[i], i == 3);
            end
        end
        @(negedge clk);
        checks++;
        if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL msb end out_valid %0b in_ready %0b exp 0 1", m_out_valid, m_in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        send(16'h0006);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_index !== 4'd1 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL hold cycle %0d got v%0b idx %0d last %0b exp v1 idx 1 last 0",
                         i, out_valid, out_index, out_last);
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain("backpressure");
    endtask

    task automatic test_zero_and_full;
        send(16'h0000);
        @(negedge clk);
        checks++;
        if (zero_in !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero pulse zero_in %0b out_valid %0b exp 1 0", zero_in, out_valid);
        end
        @(negedge clk);
        checks++;
        if (zero_in !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero end zero_in %0b out_valid %0b exp 0 0", zero_in, out_valid);
        end
        @(posedge clk);
        #1;
        send(16'hFFFF);
        drain("full");
    endtask

    task automatic test_reset_mid_emit;
        int b0 = beats;
        int n = 0;
        send(16'hFFFF);
        while (beats < b0 + 4 && n < 100) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (beats < b0 + 4) begin
            errors++;
            $display("FAIL midreset beats %0d exp %0d", beats - b0, 4);
        end
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        q.delete();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset out_valid %0b in_ready %0b exp 0 1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        send(16'h0100);
        drain("after_reset");
    endtask

    initial begin
        test_reset;
        test_single;
        test_multi;
        test_msb_first;
        test_backpressure;
        test_zero_and_full;
        test_reset_mid_emit;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
